// File: rtl/gpu_pkg.sv
// Types shared between the core scheduler and per-thread units: core pipeline
// state and load/store unit state.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: issues one read or write on the memory controller's
// valid/ready channel per LDR/STR, with an optional bounded wait that flags a hung channel.
module load_store_unit
    import gpu_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam int unsigned CNT_BITS =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_BITS'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t           state_q, state_d;
    logic                 is_read_q, is_read_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 err_q, err_d;
    logic                 ready_sel;
    logic                 timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LSU_IDLE;
            is_read_q <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            out_q     <= out_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        out_d       = out_q;
        err_d       = err_q;
        ready_sel   = is_read_q ? mem_read_ready : mem_write_ready;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

        if (!enable) begin
            state_d = LSU_IDLE;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state_d   = LSU_REQUESTING;
                        is_read_d = decoded_mem_read_enable;
                    end
                end
                LSU_REQUESTING: begin
                    // A still-high ready belongs to the previous handshake; wait it out.
                    if (!ready_sel) begin
                        state_d = LSU_WAITING;
                        addr_d  = rs[ADDR_BITS-1:0];
                        cnt_d   = '0;
                        if (!is_read_q) wdata_d = rt;
                    end
                end
                LSU_WAITING: begin
                    if (ready_sel) begin
                        state_d = LSU_DONE;
                        if (is_read_q) out_d = mem_read_data;
                    end else if (timeout_hit) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                        if (is_read_q) out_d = '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read_valid    = (state_q == LSU_WAITING) && is_read_q;
        mem_write_valid   = (state_q == LSU_WAITING) && !is_read_q;
        mem_read_address  = addr_q;
        mem_write_address = addr_q;
        mem_write_data    = wdata_q;
        lsu_state         = state_q;
        lsu_out           = out_q;
        lsu_error         = err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and randomized LDR/STR transactions against a
// transaction-level model of the load result and sticky error flag.
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en, wr_en;
    logic [7:0] rs, rt;
    logic       mem_read_valid, mem_write_valid;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data;
    logic       mem_read_ready, mem_write_ready;
    logic [7:0] mem_read_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_out;
    logic       ref_err;

    localparam logic [2:0] C_FETCH = 3'b001, C_REQ = 3'b011, C_WAIT = 3'b100, C_UPD = 3'b110;

    load_store_unit #(
        .ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .core_state              (core_state),
        .decoded_mem_read_enable (rd_en),
        .decoded_mem_write_enable(wr_en),
        .rs                      (rs),
        .rt                      (rt),
        .mem_read_valid          (mem_read_valid),
        .mem_read_address        (mem_read_address),
        .mem_read_ready          (mem_read_ready),
        .mem_read_data           (mem_read_data),
        .mem_write_valid         (mem_write_valid),
        .mem_write_address       (mem_write_address),
        .mem_write_data          (mem_write_data),
        .mem_write_ready         (mem_write_ready),
        .lsu_state               (lsu_state),
        .lsu_out                 (lsu_out),
        .lsu_error               (lsu_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction; lat = ready-low WAITING cycles before ready (>=4 times out).
    task automatic do_op(input bit rd, input logic [7:0] a, input logic [7:0] dw,
                         input logic [7:0] dr, input int lat);
        bit to;
        int n;
        to = (lat >= 4);
        n  = to ? 4 : lat;
        enable = 1'b1; core_state = C_REQ; rd_en = rd; wr_en = !rd; rs = a; rt = dw;
        step();
        check("op_requesting", lsu_state, 2'b01);
        check("op_no_valid_req", {mem_read_valid, mem_write_valid}, 2'b00);
        core_state = C_WAIT;
        step();
        for (int w = 0; w < n; w++) begin
            check("op_rvalid", mem_read_valid, rd);
            check("op_wvalid", mem_write_valid, !rd);
            check("op_addr", rd ? mem_read_address : mem_write_address, a);
            if (!rd) check("op_wdata", mem_write_data, dw);
            rs = 8'($urandom); rt = 8'($urandom); mem_read_data = 8'($urandom);
            step();
        end
        if (!to) begin
            check("op_valid_at_ready", rd ? mem_read_valid : mem_write_valid, 1'b1);
            check("op_addr_at_ready", rd ? mem_read_address : mem_write_address, a);
            if (rd) begin
                mem_read_ready = 1'b1; mem_read_data = dr;
            end else begin
                mem_write_ready = 1'b1;
            end
            step();
        end
        if (to) begin
            ref_err = 1'b1;
            if (rd) ref_out = 8'h00;
        end else if (rd) begin
            ref_out = dr;
        end
        check("op_done", lsu_state, 2'b11);
        check("op_valid_dropped", {mem_read_valid, mem_write_valid}, 2'b00);
        check("op_lsu_out", lsu_out, ref_out);
        check("op_lsu_error", lsu_error, ref_err);
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        core_state = C_UPD; rd_en = 1'b0; wr_en = 1'b0;
        step();
        check("op_idle_after_update", lsu_state, 2'b00);
        core_state = C_FETCH;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
        rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        mem_read_data = 8'h00; ref_out = 8'h00; ref_err = 1'b0;
        #1;
        check("rst_state", lsu_state, 2'b00);
        check("rst_valids", {mem_read_valid, mem_write_valid}, 2'b00);
        check("rst_out", lsu_out, 8'h00);
        check("rst_err", lsu_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();

        do_op(1'b1, 8'h2A, 8'h00, 8'h5C, 3);
        do_op(1'b0, 8'h10, 8'h77, 8'h00, 2);
        check("str_keeps_out", lsu_out, 8'h5C);

        // Back-to-back LDR while the previous ready lingers.
        enable = 1'b1; core_state = C_REQ; rd_en = 1'b1; rs = 8'h33;
        step();
        core_state = C_WAIT;
        step();
        mem_read_ready = 1'b1; mem_read_data = 8'hA1;
        step();
        ref_out = 8'hA1;
        check("b2b_first_out", lsu_out, ref_out);
        core_state = C_UPD;
        step();
        core_state = C_REQ; rs = 8'h44;
        step();
        check("b2b_req", lsu_state, 2'b01);
        core_state = C_WAIT;
        for (int i = 0; i < 2; i++) begin
            step();
            check("b2b_hold_req", lsu_state, 2'b01);
            check("b2b_no_overlap", mem_read_valid, 1'b0);
        end
        mem_read_ready = 1'b0;
        step();
        check("b2b_waiting", lsu_state, 2'b10);
        check("b2b_valid", mem_read_valid, 1'b1);
        check("b2b_addr", mem_read_address, 8'h44);
        mem_read_ready = 1'b1; mem_read_data = 8'hB2;
        step();
        ref_out = 8'hB2;
        check("b2b_done", lsu_state, 2'b11);
        check("b2b_out", lsu_out, ref_out);
        mem_read_ready = 1'b0; core_state = C_UPD; rd_en = 1'b0;
        step();
        core_state = C_FETCH;

        for (int k = 0; k < 10; k++) begin
            do_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)));
        end

        do_op(1'b1, 8'h81, 8'h00, 8'h99, 100);
        do_op(1'b1, 8'h82, 8'h00, 8'h3C, 1);
        check("err_sticky", lsu_error, 1'b1);
        for (int k = 0; k < 6; k++) begin
            do_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 5)));
        end

        // Reset while waiting.
        enable = 1'b1; core_state = C_REQ; rd_en = 1'b1; rs = 8'h6B;
        step();
        core_state = C_WAIT;
        step();
        check("rstw_valid_before", mem_read_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rstw_state", lsu_state, 2'b00);
        check("rstw_valid", mem_read_valid, 1'b0);
        check("rstw_addr", mem_read_address, 8'h00);
        check("rstw_out", lsu_out, 8'h00);
        check("rstw_err", lsu_error, 1'b0);
        ref_out = 8'h00; ref_err = 1'b0;
        @(negedge clk);
        reset = 1'b0; core_state = C_FETCH; rd_en = 1'b0;
        step();
        check("rstw_idle_after", lsu_state, 2'b00);

        // Enable dropped while waiting; later ready must be ignored.
        core_state = C_REQ; rd_en = 1'b1; rs = 8'h55;
        step();
        core_state = C_WAIT;
        step();
        check("en_waiting", lsu_state, 2'b10);
        enable = 1'b0;
        step();
        check("en_valid_low", mem_read_valid, 1'b0);
        check("en_idle", lsu_state, 2'b00);
        mem_read_ready = 1'b1; mem_read_data = 8'hEE;
        step();
        check("en_ignore_state", lsu_state, 2'b00);
        check("en_ignore_out", lsu_out, ref_out);
        mem_read_ready = 1'b0; rd_en = 1'b0; enable = 1'b1;
        do_op(1'b1, 8'h21, 8'h00, 8'h4D, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
